// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding bridge from a local req/rsp port to an AXI4-Lite initiator.
// Optional response timeout with a drain state: define AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_master_bridge #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_BYTE_COUNT = AXI_DATA_WIDTH / 8
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                      i_aclk,
  input  logic                      i_reset,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [AXI_ID_WIDTH-1:0]   i_req_id,
  input  logic [AXI_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [AXI_DATA_WIDTH-1:0] i_req_wdata,
  input  logic [AXI_BYTE_COUNT-1:0] i_req_wstrb,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic                      o_rsp_we,
  output logic [AXI_ID_WIDTH-1:0]   o_rsp_id,
  output logic [AXI_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [1:0]                o_rsp_resp,
  output logic                      o_rsp_err,
  output logic [AXI_ID_WIDTH-1:0]   o_awid,
  output logic [AXI_ADDR_WIDTH-1:0] o_awaddr,
  output logic [2:0]                o_awprot,
  output logic                      o_awvalid,
  input  logic                      i_awready,
  output logic [AXI_DATA_WIDTH-1:0] o_wdata,
  output logic [AXI_BYTE_COUNT-1:0] o_wstrb,
  output logic                      o_wvalid,
  input  logic                      i_wready,
  input  logic [AXI_ID_WIDTH-1:0]   i_bid,
  input  logic [1:0]                i_bresp,
  input  logic                      i_bvalid,
  output logic                      o_bready,
  output logic [AXI_ID_WIDTH-1:0]   o_arid,
  output logic [AXI_ADDR_WIDTH-1:0] o_araddr,
  output logic [2:0]                o_arprot,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  input  logic [AXI_ID_WIDTH-1:0]   i_rid,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rvalid,
  output logic                      o_rready
);

  // state          | meaning
  // S_IDLE         | req_ready high, waiting for a local request
  // S_WR_ADDR_DATA | AW and W offered independently until both handshaken
  // S_WR_RESP      | bready high, waiting for B
  // S_RD_ADDR      | arvalid high, waiting for arready
  // S_RD_DATA      | rready high, waiting for R
  // S_RESP         | rsp_valid held until rsp_ready
  // S_DRAIN        | timed out; absorbing the late B/R (timeout build only)
  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RESP, S_DRAIN
  } state_t;

  state_t                    r_state;
  logic                      r_req_ready, r_we, r_aw_done, r_w_done;
  logic                      r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [AXI_BYTE_COUNT-1:0] r_wstrb;
  logic                      r_rsp_valid, r_rsp_we, r_rsp_err;
  logic [AXI_ID_WIDTH-1:0]   r_rsp_id;
  logic [AXI_DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]                r_rsp_resp;

  logic w_accept, w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic w_b_mismatch, w_r_mismatch, w_tmo, w_waiting;

  assign w_accept     = i_req_valid & r_req_ready;
  assign w_aw_hs      = r_awvalid & i_awready;
  assign w_w_hs       = r_wvalid & i_wready;
  assign w_ar_hs      = r_arvalid & i_arready;
  assign w_b_hs       = r_bready & i_bvalid;
  assign w_r_hs       = r_rready & i_rvalid;
  assign w_b_mismatch = (i_bid != r_id);
  assign w_r_mismatch = (i_rid != r_id);
  assign w_waiting    = (r_state == S_WR_ADDR_DATA) || (r_state == S_WR_RESP) ||
                        (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo_cnt;

  always_ff @(posedge i_aclk) begin
    if (i_reset || w_accept) r_tmo_cnt <= '0;
    else if (w_waiting)      r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  assign w_tmo = w_waiting && (r_tmo_cnt == LP_TMO_LAST);
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_we        <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_id        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      // Timeout report shares one shape; later branches override where needed.
      if (w_tmo) begin
        r_rsp_valid <= 1'b1;
        r_rsp_we    <= r_we;
        r_rsp_id    <= r_id;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= 2'b10;
        r_rsp_err   <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_we        <= i_req_we;
            r_id        <= i_req_id;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_wstrb     <= i_req_wstrb;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            if (i_req_we) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_ADDR_DATA;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR_ADDR_DATA: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end else if (w_tmo) begin
            // Slave never took the request, so no late B is expected.
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_state   <= S_RESP;
          end
        end
        S_WR_RESP: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_rdata <= '0;
            r_rsp_err   <= i_bresp[1] | w_b_mismatch;
            r_rsp_resp  <= w_b_mismatch ? 2'b10 : i_bresp;
            r_state     <= S_RESP;
          end else if (w_tmo) begin
            r_state <= S_DRAIN;
          end
        end
        S_RD_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end else if (w_tmo) begin
            r_arvalid <= 1'b0;
            r_state   <= S_RESP;
          end
        end
        S_RD_DATA: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= 1'b0;
            r_rsp_id    <= r_id;
            r_rsp_rdata <= i_rdata;
            r_rsp_err   <= i_rresp[1] | w_r_mismatch;
            r_rsp_resp  <= w_r_mismatch ? 2'b10 : i_rresp;
            r_state     <= S_RESP;
          end else if (w_tmo) begin
            r_state <= S_DRAIN;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (r_rsp_valid && i_rsp_ready) r_rsp_valid <= 1'b0;
          if (w_b_hs || w_r_hs) begin
            r_bready <= 1'b0;
            r_rready <= 1'b0;
          end
          if ((!(r_bready || r_rready) || w_b_hs || w_r_hs) &&
              (!r_rsp_valid || i_rsp_ready)) begin
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_we    = r_rsp_we;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_resp  = r_rsp_resp;
  assign o_rsp_err   = r_rsp_err;
  assign o_awid      = r_id;
  assign o_awaddr    = r_addr;
  assign o_awprot    = 3'b000;
  assign o_awvalid   = r_awvalid;
  assign o_wdata     = r_wdata;
  assign o_wstrb     = r_wstrb;
  assign o_wvalid    = r_wvalid;
  assign o_bready    = r_bready;
  assign o_arid      = r_id;
  assign o_araddr    = r_addr;
  assign o_arprot    = 3'b000;
  assign o_arvalid   = r_arvalid;
  assign o_rready    = r_rready;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Bench for axi4_lite_master_bridge: directed and random transactions against a behavioural slave and response model.
// Defining AXI4_LITE_MASTER_TIMEOUT_EN also runs the timeout/drain scenario with TIMEOUT_CYCLES=8.
module tb_axi4_lite_master_bridge;
  logic        i_aclk = 1'b0;
  logic        i_reset, i_req_valid, o_req_ready, i_req_we;
  logic [0:0]  i_req_id;
  logic [11:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_wstrb;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_we, o_rsp_err;
  logic [0:0]  o_rsp_id;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic [0:0]  o_awid, i_bid, o_arid, i_rid;
  logic [11:0] o_awaddr, o_araddr;
  logic [2:0]  o_awprot, o_arprot;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;
  logic [31:0] o_wdata, i_rdata;
  logic [3:0]  o_wstrb;
  logic [1:0]  i_bresp, i_rresp;

  int total = 0;
  int bad = 0;

  always #5 i_aclk = ~i_aclk;

  axi4_lite_master_bridge #(
    .AXI_ID_WIDTH(1)
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .i_aclk(i_aclk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_id(i_req_id), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_req_wstrb(i_req_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_we(o_rsp_we),
    .o_rsp_id(o_rsp_id), .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
    .o_rsp_err(o_rsp_err),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awprot(o_awprot), .o_awvalid(o_awvalid),
    .i_awready(i_awready), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid),
    .i_wready(i_wready), .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid),
    .o_bready(o_bready), .o_arid(o_arid), .o_araddr(o_araddr), .o_arprot(o_arprot),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .i_rid(i_rid), .i_rdata(i_rdata),
    .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: request, slave with given wait states, response with hold.
  task automatic run_txn(input logic we, input logic [0:0] id, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int aw_dly, input int w_dly, input int resp_dly,
                         input logic [1:0] xresp, input logic [0:0] xid,
                         input logic [31:0] rd, input int hold);
    int guard, aw_hi, w_hi, rwait, cyc;
    logic aw_ok, w_ok, done, stable, extra, hs_aw, hs_w, hs_x, awv, wv;
    logic mism, exp_err;
    logic [1:0] exp_resp;
    logic [31:0] exp_rdata;
    mism      = (xid != id);
    exp_err   = xresp[1] | mism;
    exp_resp  = mism ? 2'b10 : xresp;
    exp_rdata = we ? 32'h0 : rd;

    guard = 0;
    while (o_req_ready !== 1'b1 && guard < 50) begin
      @(negedge i_aclk);
      guard++;
    end
    chk("req_ready_idle", o_req_ready, 1);
    i_req_valid = 1'b1; i_req_we = we; i_req_id = id;
    i_req_addr = addr; i_req_wdata = wd; i_req_wstrb = ws;
    @(negedge i_aclk);
    i_req_valid = 1'b0; i_req_id = ~id;
    i_req_addr = 12'($urandom); i_req_wdata = $urandom; i_req_wstrb = 4'($urandom);
    chk("req_ready_busy", o_req_ready, 0);
    if (we) chk("aw_w_valid_rise", {o_awvalid, o_wvalid, o_arvalid}, 3'b110);
    else    chk("ar_valid_rise", {o_awvalid, o_wvalid, o_arvalid}, 3'b001);
    chk("addr_payload", we ? {o_awid, o_awaddr, o_awprot} : {o_arid, o_araddr, o_arprot},
        {id, addr, 3'b000});
    if (we) chk("w_payload", {o_wstrb, o_wdata}, {ws, wd});

    aw_ok = 1'b0; w_ok = !we; aw_hi = 0; w_hi = 0; rwait = 0; cyc = 0;
    done = 1'b0; stable = 1'b1; extra = 1'b0;
    while (!done && cyc < 100) begin
      cyc++;
      awv = we ? o_awvalid : o_arvalid;
      wv  = we ? o_wvalid : 1'b0;
      if (!aw_ok) begin
        if (awv) begin
          aw_hi++;
          if ((we ? o_awaddr : o_araddr) !== addr) stable = 1'b0;
        end
      end else if (awv) extra = 1'b1;
      if (!w_ok) begin
        if (wv) begin
          w_hi++;
          if (o_wdata !== wd || o_wstrb !== ws) stable = 1'b0;
        end
      end else if (wv) extra = 1'b1;
      if (o_rsp_valid) extra = 1'b1;
      hs_aw = !aw_ok && awv && (aw_hi > aw_dly);
      hs_w  = !w_ok && wv && (w_hi > w_dly);
      i_awready = we & hs_aw;
      i_arready = !we & hs_aw;
      i_wready  = hs_w;
      hs_x = 1'b0;
      if (aw_ok && w_ok) begin
        rwait++;
        if (rwait > resp_dly) begin
          if (we) begin
            i_bvalid = 1'b1; i_bid = xid; i_bresp = xresp; hs_x = o_bready;
          end else begin
            i_rvalid = 1'b1; i_rid = xid; i_rresp = xresp; i_rdata = rd; hs_x = o_rready;
          end
        end
      end
      @(negedge i_aclk);
      if (hs_aw) aw_ok = 1'b1;
      if (hs_w)  w_ok = 1'b1;
      if (hs_x)  done = 1'b1;
      i_awready = 1'b0; i_arready = 1'b0; i_wready = 1'b0;
    end
    i_bvalid = 1'b0; i_rvalid = 1'b0; i_rdata = $urandom; i_bresp = 2'($urandom);
    chk("resp_handshake_budget", done, 1);
    chk("addr_valid_cycles", aw_hi, aw_dly + 1);
    if (we) chk("w_valid_cycles", w_hi, w_dly + 1);
    chk("payload_stable", stable, 1);
    chk("no_stray_valid", extra, 0);
    chk("rsp_valid_latency", o_rsp_valid, 1);
    chk("rsp_fields", {o_rsp_we, o_rsp_id, o_rsp_resp, o_rsp_err, o_rsp_rdata},
        {we, id, exp_resp, exp_err, exp_rdata});
    chk("xready_drop", {o_bready, o_rready}, 2'b00);

    stable = 1'b1; extra = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge i_aclk);
      if (o_rsp_valid !== 1'b1 ||
          {o_rsp_we, o_rsp_id, o_rsp_resp, o_rsp_err, o_rsp_rdata} !==
          {we, id, exp_resp, exp_err, exp_rdata}) stable = 1'b0;
      if (o_req_ready || o_awvalid || o_wvalid || o_arvalid) extra = 1'b1;
    end
    chk("rsp_hold_stable_quiet", {stable, extra}, 2'b10);
    i_rsp_ready = 1'b1;
    @(negedge i_aclk);
    i_rsp_ready = 1'b0;
    chk("rsp_consumed", {o_rsp_valid, o_req_ready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_id = '0;
    i_req_addr = '0; i_req_wdata = '0; i_req_wstrb = '0; i_rsp_ready = 1'b0;
    i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0;
    i_bvalid = 1'b0; i_bid = '0; i_bresp = '0;
    i_rvalid = 1'b0; i_rid = '0; i_rdata = '0; i_rresp = '0;

    repeat (3) @(negedge i_aclk);
    chk("reset_req_ready", o_req_ready, 0);
    chk("reset_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid, o_rsp_err},
        7'b0);
    chk("reset_rsp_data", {o_rsp_resp, o_rsp_rdata}, 34'h0);
    i_reset = 1'b0;
    @(negedge i_aclk);
    chk("post_reset_req_ready", o_req_ready, 1);

    // Reset in the middle of a write drops the AXI valids.
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 12'h100; i_req_wdata = 32'h1;
    @(negedge i_aclk);
    i_req_valid = 1'b0;
    chk("midreset_pre", {o_awvalid, o_wvalid}, 2'b11);
    i_reset = 1'b1;
    @(negedge i_aclk);
    chk("midreset_drop", {o_awvalid, o_wvalid, o_req_ready}, 3'b000);
    i_reset = 1'b0;
    @(negedge i_aclk);
    chk("midreset_recover", o_req_ready, 1);

    run_txn(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 1'b1, 32'h0, 0);
    run_txn(1'b1, 1'b0, 12'h0A4, 32'h0BAD_F00D, 4'h3, 3, 0, 0, 2'b00, 1'b0, 32'h0, 1);
    run_txn(1'b0, 1'b1, 12'h020, 32'h0, 4'h0, 0, 0, 0, 2'b10, 1'b1, 32'h12345678, 0);
    run_txn(1'b0, 1'b0, 12'h030, 32'h0, 4'h0, 1, 0, 2, 2'b00, 1'b1, 32'hCAFEF00D, 0);
    run_txn(1'b1, 1'b1, 12'h044, 32'h5A5A0001, 4'h1, 0, 2, 1, 2'b01, 1'b1, 32'h0, 5);

    for (int n = 0; n < 40; n++) begin
      logic       r_we;
      logic [0:0] r_id, r_xid;
      r_we  = 1'($urandom);
      r_id  = 1'($urandom);
      r_xid = ($urandom_range(0, 3) == 0) ? ~r_id : r_id;
      run_txn(r_we, r_id, 12'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom), r_xid, $urandom, $urandom_range(0, 3));
    end

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    begin
      int k;
      while (o_req_ready !== 1'b1) @(negedge i_aclk);
      i_req_valid = 1'b1; i_req_we = 1'b1; i_req_id = 1'b0;
      i_req_addr = 12'h070; i_req_wdata = 32'h77; i_req_wstrb = 4'hF;
      @(negedge i_aclk);
      i_req_valid = 1'b0;
      k = 1;
      i_awready = 1'b1; i_wready = 1'b1;
      while (o_rsp_valid !== 1'b1 && k < 30) begin
        @(negedge i_aclk);
        i_awready = 1'b0; i_wready = 1'b0;
        k++;
      end
      chk("tmo_latency", k, 9);
      chk("tmo_rsp", {o_rsp_err, o_rsp_resp, o_rsp_rdata}, {1'b1, 2'b10, 32'h0});
      i_rsp_ready = 1'b1;
      @(negedge i_aclk);
      k++;
      i_rsp_ready = 1'b0;
      chk("tmo_drain", {o_rsp_valid, o_req_ready, o_bready}, 3'b001);
      while (k < 20) begin
        @(negedge i_aclk);
        k++;
      end
      chk("tmo_drain_hold", {o_req_ready, o_bready}, 2'b01);
      i_bvalid = 1'b1; i_bid = 1'b0; i_bresp = 2'b00;
      @(negedge i_aclk);
      i_bvalid = 1'b0;
      chk("tmo_drain_exit", {o_req_ready, o_bready, o_rsp_valid}, 3'b100);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
